// File: rtl/sdf4_stage_ctrl.sv
// rtl/sdf4_stage_ctrl.sv - radix-4 SDF stage controller (sequencing, butterfly enable, twiddle addressing)
// Optional end-of-stream drain compiled in with `define SDF4_FLUSH_EN.
module sdf4_stage_ctrl #(
  parameter int DEPTH = 32,
  localparam int IW = $clog2(DEPTH),
  localparam int CW = IW + 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          buf_enable,
  output logic [1:0]    phase,
  output logic          bf_enable,
  output logic          out_valid,
  output logic          frame_start,
  output logic [CW-1:0] tw_addr
);

`ifdef SDF4_FLUSH_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;
`endif

  localparam logic [CW-1:0] FLUSH_LAST = CW'(3 * DEPTH - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] ocnt;
  logic          primed;
  logic          flushing;
  logic          advance;
  logic          emit;
  logic [1:0]    leg;
  logic [IW-1:0] idx;
  logic [CW-1:0] tw_next;

`ifdef SDF4_FLUSH_EN
  assign flushing = (state == S_FLUSH);
  assign in_ready = (state != S_FLUSH);
`else
  assign flushing = 1'b0;
  assign in_ready = 1'b1;
`endif

  // Reset gating keeps the delay buffers frozen while reset is held, even if in_valid is high.
  assign advance    = !reset && ((in_valid && in_ready) || flushing);
  assign phase      = cnt[CW-1:CW-2];
  assign buf_enable = advance;
  assign bf_enable  = advance && (phase == 2'd3);
  assign emit       = advance && ((phase == 2'd3) || primed);

  assign leg     = ocnt[CW-1:CW-2];
  assign idx     = ocnt[IW-1:0];
  assign tw_next = {{IW{1'b0}}, leg} * {2'b00, idx};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      ocnt        <= '0;
      primed      <= 1'b0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      tw_addr     <= '0;
    end else begin
      out_valid <= emit;
      if (emit) begin
        tw_addr     <= tw_next;
        frame_start <= (ocnt == '0);
        ocnt        <= ocnt + CW'(1);
      end else begin
        tw_addr     <= '0;
        frame_start <= 1'b0;
      end

      if (advance) begin
        cnt <= cnt + CW'(1);
      end
      if (advance && (phase == 2'd3)) begin
        primed <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (advance && (phase == 2'd3)) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
`ifdef SDF4_FLUSH_EN
          // A gap exactly on a frame boundary marks end of stream.
          if ((cnt == '0) && !in_valid) begin
            state <= S_FLUSH;
          end
`endif
        end
`ifdef SDF4_FLUSH_EN
        S_FLUSH: begin
          // Every flush cycle advances, so cnt doubles as the drain counter.
          if (cnt == FLUSH_LAST) begin
            state  <= S_IDLE;
            primed <= 1'b0;
            cnt    <= '0;
            ocnt   <= '0;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdf4_stage_ctrl.sv
// tb/tb_sdf4_stage_ctrl.sv - self-checking bench for sdf4_stage_ctrl (DEPTH=4), with or without SDF4_FLUSH_EN
module tb_sdf4_stage_ctrl;
  localparam int D  = 4;
  localparam int CW = 4;
  localparam int F  = 4 * D;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          buf_enable;
  logic [1:0]    phase;
  logic          bf_enable;
  logic          out_valid;
  logic          frame_start;
  logic [CW-1:0] tw_addr;

  always #5 clock = ~clock;

  sdf4_stage_ctrl #(.DEPTH(D)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .buf_enable (buf_enable),
    .phase      (phase),
    .bf_enable  (bf_enable),
    .out_valid  (out_valid),
    .frame_start(frame_start),
    .tw_addr    (tw_addr)
  );

  int checks = 0;
  int errors = 0;

  // Model: samples accepted in current frame, outputs emitted, drain cycles left.
  int m_n, m_k, m_flush;
  bit m_primed;
  int e_ov, e_fs, e_tw;

  int lg_tw[$];
  int lg_fs[$];
  int n_bf, n_nrdy;
  int lit[16] = '{0,0,0,0, 0,1,2,3, 0,2,4,6, 0,3,6,9};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_k = 0; m_flush = 0; m_primed = 0;
    e_ov = 0; e_fs = 0; e_tw = 0;
  endtask

  task automatic clear_logs();
    lg_tw.delete(); lg_fs.delete(); n_bf = 0; n_nrdy = 0;
  endtask

  task automatic step(input bit iv, input bit rs);
    int ph;
    bit rdy, adv, fire;
    @(negedge clock);
    in_valid = iv;
    reset    = rs;
    if (rs) model_reset();
    #1;
    rdy = (m_flush == 0);
    adv = !rs && ((iv && rdy) || (m_flush > 0));
    ph  = m_n / D;
    chk("in_ready",    int'(in_ready),    int'(rdy));
    chk("buf_enable",  int'(buf_enable),  int'(adv));
    chk("bf_enable",   int'(bf_enable),   int'(adv && ph == 3));
    chk("phase",       int'(phase),       ph);
    chk("out_valid",   int'(out_valid),   e_ov);
    chk("frame_start", int'(frame_start), e_fs);
    chk("tw_addr",     int'(tw_addr),     e_tw);
    if (out_valid) begin
      lg_tw.push_back(int'(tw_addr));
      lg_fs.push_back(int'(frame_start));
    end
    if (bf_enable) n_bf++;
    if (!in_ready) n_nrdy++;
    // Expected state after the coming rising edge.
    fire = adv && (ph == 3 || m_primed);
    e_ov = int'(fire);
    e_tw = fire ? (m_k / D) * (m_k % D) : 0;
    e_fs = int'(fire && m_k == 0);
    if (fire) m_k = (m_k + 1) % F;
    if (adv && ph == 3) m_primed = 1;
    if (adv) m_n = (m_n + 1) % F;
`ifdef SDF4_FLUSH_EN
    if (m_flush > 0) begin
      m_flush--;
      if (m_flush == 0) begin
        m_primed = 0; m_n = 0; m_k = 0;
      end
    end else if (!rs && m_primed && m_n == 0 && !iv) begin
      m_flush = 3 * D;
    end
`endif
  endtask

  initial begin
    int fs_rest;
    reset    = 1'b1;
    in_valid = 1'b0;
    model_reset();
    repeat (2) step(0, 1);

    // One full frame back-to-back, then idle.
    clear_logs();
    repeat (16) step(1, 0);
    repeat (20) step(0, 0);
    chk("bf_count", n_bf, 4);
`ifdef SDF4_FLUSH_EN
    chk("outs_after_idle", lg_tw.size(), 16);
    chk("not_ready_cycles", n_nrdy, 12);
`else
    chk("outs_after_idle", lg_tw.size(), 4);
    chk("not_ready_cycles", n_nrdy, 0);
`endif
    repeat (12) step(1, 0);
    repeat (3) step(0, 0);
    chk("outs_total", lg_tw.size(), 16);
    for (int i = 0; i < 16; i++)
      chk("tw_seq", (i < lg_tw.size()) ? lg_tw[i] : -1, lit[i]);
    chk("frame_start_first", (lg_fs.size() > 0) ? lg_fs[0] : -1, 1);
    fs_rest = 0;
    for (int i = 1; i < lg_fs.size(); i++) fs_rest += lg_fs[i];
    chk("frame_start_rest", fs_rest, 0);

    // Asynchronous reset while outputs are active.
    step(1, 0);
    step(1, 0);
    chk("pre_rst_out_valid", int'(out_valid), 1);
    step(1, 1);
    chk("rst_out_valid",  int'(out_valid),  0);
    chk("rst_tw_addr",    int'(tw_addr),    0);
    chk("rst_in_ready",   int'(in_ready),   1);
    chk("rst_buf_enable", int'(buf_enable), 0);
    chk("rst_phase",      int'(phase),      0);

    // Alternating valid: same output order, gaps only stretch it.
    clear_logs();
    for (int i = 0; i < 32; i++) step(i % 2 == 0, 0);
    repeat (20) step(0, 0);
    chk("gap_bf_count", n_bf, 4);
`ifdef SDF4_FLUSH_EN
    chk("gap_outs", lg_tw.size(), 16);
`else
    chk("gap_outs", lg_tw.size(), 4);
`endif
    for (int i = 0; i < lg_tw.size() && i < 16; i++)
      chk("gap_tw_seq", lg_tw[i], lit[i]);

    // Randomized traffic with bursts, gaps and occasional resets.
    for (int blk = 0; blk < 120; blk++) begin
      int dens;
      dens = $urandom_range(0, 3);
      for (int c = 0; c < 25; c++) begin
        bit iv, rs;
        iv = ($urandom_range(0, 3) < dens + 1);
        if (dens == 3) iv = 1'b1;
        rs = ($urandom_range(0, 299) == 0);
        step(iv, rs);
      end
    end
    repeat (20) step(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdf4_stage_ctrl.md
SDF4_STAGE_CTRL -- requirements
Module: sdf4_stage_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 32: delay-buffer depth of the controlled radix-4 SDF stage; power of 2, at least 2.
REQ-002 SHALL derive localparam IW = log2(DEPTH) (sample-index width) and CW = IW+2 (frame-counter width).
REQ-003 SHALL have port clock, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: input sample present this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: controller accepts a sample this cycle.
REQ-007 SHALL have port buf_enable, output, 1 bit: shift enable for the stage's three DelayBuffers (combinational).
REQ-008 SHALL have port phase, output, 2 bits: current input quarter, cnt[CW-1:CW-2] (combinational from state).
REQ-009 SHALL have port bf_enable, output, 1 bit: butterfly compute enable (combinational).
REQ-010 SHALL have port out_valid, output, 1 bit: stage output sample valid (registered).
REQ-011 SHALL have port frame_start, output, 1 bit: first output of a 4*DEPTH frame (registered).
REQ-012 SHALL have port tw_addr, output, CW bits: twiddle ROM address for the current output (registered).

Function
REQ-013 SHALL define advance = (in_valid && in_ready) || flushing; cnt (CW bits) SHALL increment on advance and wrap from 4*DEPTH-1 to 0.
REQ-014 SHALL drive buf_enable = advance and bf_enable = advance && phase==3.
REQ-015 SHALL hold cnt and all enables low on cycles with no advance; gaps SHALL not disturb alignment.
REQ-016 SHALL set the internal flag primed on the first advance with phase==3.
REQ-017 SHALL register out_valid <= advance && (phase==3 || primed), giving 1-cycle latency from the accepting edge.
REQ-018 SHALL keep output counter ocnt (CW bits), incremented on each out_valid and wrapping at 4*DEPTH; leg = ocnt[CW-1:CW-2], idx = ocnt[IW-1:0].
REQ-019 SHALL register tw_addr <= leg*idx (range 0..3*(DEPTH-1)) and frame_start <= (ocnt==0), both aligned with out_valid.
REQ-020 SHALL drive tw_addr and frame_start to 0 whenever out_valid is low.
REQ-021 SHALL implement states IDLE (not primed), RUN (primed), and FLUSH (only when the macro is defined): IDLE->RUN on primed set; RUN->FLUSH per REQ-026; FLUSH->IDLE after 3*DEPTH flush advances.
REQ-022 SHALL hold in_ready = 1 in IDLE and RUN.

Reset
REQ-023 SHALL clear cnt, ocnt, primed, state (IDLE), out_valid, frame_start and tw_addr asynchronously on reset; in_ready SHALL read 1 and buf_enable/bf_enable SHALL read 0 during reset.
REQ-024 SHALL discard any partial frame on reset asserted mid-frame or mid-flush; the next accepted sample is index 0 of a new frame.

Configuration
REQ-025 SHALL use macro SDF4_FLUSH_EN to compile the drain feature in or out.
REQ-026 With SDF4_FLUSH_EN: in RUN with cnt==0 and in_valid low, SHALL enter FLUSH next edge; in FLUSH, flushing=1, in_ready=0, in_valid ignored, then clear primed and return to IDLE.
REQ-027 Without SDF4_FLUSH_EN: flushing SHALL be constant 0, in_ready constant 1, no FLUSH state; trailing outputs SHALL emerge only as later input is accepted.

Verification (DEPTH=4)
REQ-028 Reset: assert reset mid-run -> out_valid=0, tw_addr=0, cnt=0, in_ready=1 immediately, without a clock edge.
REQ-029 16 back-to-back samples -> bf_enable high on samples 12..15; out_valid first high the cycle after sample 12 is accepted, with frame_start=1; tw_addr sequence 0,0,0,0,0,1,2,3,0,2,4,6,0,3,6,9 across consecutive frames.
REQ-030 in_valid toggled 1,0,1,0 -> cnt advances only on high cycles, with no enables during gaps; output sequence matches REQ-029 with gaps inserted.
REQ-031 SDF4_FLUSH_EN, exactly 16 samples then idle -> in_ready=0 for 12 cycles, 12 further out_valid with tw_addr 0,1,2,3,0,2,4,6,0,3,6,9; then IDLE with in_ready=1.
REQ-032 SDF4_FLUSH_EN, in_valid held high during flush -> cnt and ocnt follow the flush only and no extra outputs occur; first post-flush sample has cnt=0.
REQ-033 Without SDF4_FLUSH_EN, 16 samples then idle -> exactly 4 out_valid pulses; the remaining 12 appear only when the next 12 samples are accepted.
